// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX/MEM branch resolution,
// data-memory freeze and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned BR_RECOVER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_is_greater,
    input  logic [3:0]       exmem_func,
    input  logic             exmem_memaccess,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             pc_src,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StRecover = 2'd2
    } state_e;

    localparam logic [1:0] RecoverInit = 2'(BR_RECOVER - 1);

    state_e     state_q;
    logic [1:0] rcnt_q;

    logic hold;
    logic cond;
    logic taken;
    logic load_use;
    logic unused_func;

    // funct7[5] does not distinguish any supported branch
    assign unused_func = exmem_func[3];

    assign hold = exmem_memaccess & ~mem_ready;

    always_comb begin
        cond = 1'b0;
        case (exmem_func[2:0])
            3'b000:  cond = exmem_zero;
            3'b001:  cond = ~exmem_zero;
            3'b100:  cond = ~exmem_is_greater & ~exmem_zero;
            3'b101:  cond = exmem_is_greater | exmem_zero;
            default: cond = 1'b0;
        endcase
    end

    assign taken    = exmem_branch & cond;
    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        pc_src      = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hold) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use && (state_q != StRecover)) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            rcnt_q      <= 2'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            case (state_q)
                StRun, StMemWait: begin
                    if (hold) begin
                        state_q <= StMemWait;
                    end else if (taken) begin
                        state_q <= StRecover;
                        rcnt_q  <= RecoverInit;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRecover: begin
                    // hold freezes the recover window; a new taken branch restarts it
                    if (!hold) begin
                        if (taken) begin
                            rcnt_q <= RecoverInit;
                        end else if (rcnt_q == 2'd0) begin
                            state_q <= StRun;
                        end else begin
                            rcnt_q <= rcnt_q - 2'd1;
                        end
                    end
                end
                default: state_q <= StRun;
            endcase

            if (!pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (taken && !hold && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: the driver queues the expected response of each
// cycle and a separate monitor pops and compares it against both DUT instances.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idex_memread;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        exmem_branch, exmem_zero, exmem_is_greater;
    logic [3:0]  exmem_func;
    logic        exmem_memaccess, mem_ready;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_src;
    logic [1:0]  state;
    logic [31:0] stall_count, flush_count;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush;
    logic        s_pipe_hold, s_pc_src;
    logic [1:0]  s_state;
    logic [2:0]  s_stall_count, s_flush_count;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .exmem_is_greater(exmem_is_greater), .exmem_func(exmem_func),
        .exmem_memaccess(exmem_memaccess), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
        .pc_src(pc_src), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow counters so saturation is reachable in a short run
    hazard_ctrl #(.CNT_W(3), .BR_RECOVER(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .exmem_is_greater(exmem_is_greater), .exmem_func(exmem_func),
        .exmem_memaccess(exmem_memaccess), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .pipe_hold(s_pipe_hold),
        .pc_src(s_pc_src), .state(s_state),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_src}
    localparam logic [6:0] CRst   = 7'b0011100;
    localparam logic [6:0] CIdle  = 7'b1100000;
    localparam logic [6:0] CStall = 7'b0001000;
    localparam logic [6:0] CTaken = 7'b1111101;
    localparam logic [6:0] CHold  = 7'b0000010;

    typedef struct {
        int          idx;
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [2:0]  ssc;
        logic [2:0]  sfc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   vec_idx = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, req);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("ctrl", e.idx, 32'({pc_write, ifid_write, ifid_flush, idex_flush,
                                      exmem_flush, pipe_hold, pc_src}), 32'(e.ctrl));
            check("state", e.idx, 32'(state), 32'(e.st));
            check("stall_count", e.idx, stall_count, e.sc);
            check("flush_count", e.idx, flush_count, e.fc);
            check("sat_stall_count", e.idx, 32'(s_stall_count), 32'(e.ssc));
            check("sat_flush_count", e.idx, 32'(s_flush_count), 32'(e.sfc));
        end
    end

    // Apply one cycle of inputs after the edge and queue its expected response
    task automatic vec(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic br,
                       input logic z, input logic gt, input logic [3:0] fn,
                       input logic ma, input logic rdy, input logic [6:0] ctrl,
                       input logic [1:0] st, input int unsigned sc, input int unsigned fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; idex_memread = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        exmem_branch = br; exmem_zero = z; exmem_is_greater = gt; exmem_func = fn;
        exmem_memaccess = ma; mem_ready = rdy;
        vec_idx++;
        e.idx = vec_idx; e.ctrl = ctrl; e.st = st; e.sc = sc; e.fc = fc;
        e.ssc = (sc > 7) ? 3'd7 : 3'(sc);
        e.sfc = (fc > 7) ? 3'd7 : 3'(fc);
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; idex_memread = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
        exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_is_greater = 1'b0; exmem_func = '0;
        exmem_memaccess = 1'b0; mem_ready = 1'b1;

        //  r  mr rd  r1  r2  br z  gt fn       ma rdy ctrl    st  sc fc
        vec(0, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CRst,   0, 0, 0);
        vec(0, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CRst,   0, 0, 0);
        vec(0, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CRst,   0, 0, 0);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  0, 0, 0);
        // load-use on rs2, rd=0 ignored, load-use on rs1, no load
        vec(1, 1, 5,  0,  5,  0, 0, 0, 4'b0000, 0, 1, CStall, 0, 0, 0);
        vec(1, 1, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  0, 1, 0);
        vec(1, 1, 7,  7,  3,  0, 0, 0, 4'b0000, 0, 1, CStall, 0, 1, 0);
        vec(1, 0, 7,  7,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  0, 2, 0);
        // beq taken, load-use suppressed in RECOVER, then stalls in RUN
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 0, 1, CTaken, 0, 2, 0);
        vec(1, 1, 5,  5,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  2, 2, 1);
        vec(1, 1, 5,  5,  0,  0, 0, 0, 4'b0000, 0, 1, CStall, 0, 2, 1);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  0, 3, 1);
        // branch conditions
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0001, 0, 1, CIdle,  0, 3, 1);
        vec(1, 0, 0,  0,  0,  1, 0, 0, 4'b0100, 0, 1, CTaken, 0, 3, 1);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0101, 0, 1, CTaken, 2, 3, 2);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0010, 0, 1, CIdle,  2, 3, 3);
        vec(1, 0, 0,  0,  0,  1, 0, 1, 4'b0101, 0, 1, CTaken, 0, 3, 3);
        vec(1, 0, 0,  0,  0,  1, 0, 1, 4'b0100, 0, 1, CIdle,  2, 3, 4);
        vec(1, 0, 0,  0,  0,  0, 1, 0, 4'b0000, 0, 1, CIdle,  0, 3, 4);
        // taken with load-use: flush wins, no stall
        vec(1, 1, 5,  5,  0,  1, 1, 0, 4'b0000, 0, 1, CTaken, 0, 3, 4);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  2, 3, 5);
        // memory wait with a pending taken branch, released with mem_ready
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 1, 0, CHold,  0, 3, 5);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 1, 0, CHold,  1, 4, 5);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 1, 0, CHold,  1, 5, 5);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 1, 0, CHold,  1, 6, 5);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 1, 1, CTaken, 1, 7, 5);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  2, 7, 6);
        // hold inside RECOVER freezes the window
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 0, 1, CTaken, 0, 7, 6);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 1, 0, CHold,  2, 7, 7);
        vec(1, 1, 5,  5,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  2, 8, 7);
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 0, 1, CTaken, 0, 8, 7);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  2, 8, 8);
        // async reset during MEM_WAIT
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 1, 0, CHold,  0, 8, 8);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 1, 0, CHold,  1, 9, 8);
        vec(0, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 1, 0, CRst,   0, 0, 0);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  0, 0, 0);
        // async reset during RECOVER
        vec(1, 0, 0,  0,  0,  1, 1, 0, 4'b0000, 0, 1, CTaken, 0, 0, 0);
        vec(0, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CRst,   0, 0, 0);
        vec(1, 1, 9,  0,  9,  0, 0, 0, 4'b0000, 0, 1, CStall, 0, 0, 0);
        vec(1, 0, 0,  0,  0,  0, 0, 0, 4'b0000, 0, 1, CIdle,  0, 1, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0 pending entries", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives write-enable, hold and flush controls for PC, IF/ID, ID/EX and EX/MEM (the EX/MEM flush feeds the existing flush input).
- Detects load-use hazards, resolves branches from EX/MEM outputs, and freezes the pipe while data memory is not ready.
- Keeps saturating stall and flush event counters for the sorting benchmarks.

Parameters:
CNT_W, 32, width of stall_count and flush_count
BR_RECOVER, 1, cycles load-use detection is suppressed after a taken branch (1..3)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
idex_memread  input  1  ID/EX stage holds a load
idex_rd  input  5  ID/EX destination register
ifid_rs1  input  5  IF/ID source register 1
ifid_rs2  input  5  IF/ID source register 2
exmem_branch  input  1  EX/MEM holds a branch
exmem_zero  input  1  EX/MEM zero flag
exmem_is_greater  input  1  EX/MEM signed greater flag (rs1 > rs2)
exmem_func  input  4  EX/MEM {funct7[5],funct3}
exmem_memaccess  input  1  EX/MEM memread OR memwrite
mem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID clear
idex_flush  output  1  ID/EX clear (bubble)
exmem_flush  output  1  EX/MEM clear
pipe_hold  output  1  all pipeline registers hold contents
pc_src  output  1  select branch target (EX/MEM addsum)
state  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 RECOVER
stall_count  output  CNT_W  cycles with pc_write=0
flush_count  output  CNT_W  taken branches

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, counters=0, recover counter=0.
  - Outputs forced during reset: pc_write=0, ifid_write=0, pipe_hold=0, pc_src=0, all three flushes=1.
- Control outputs are combinational from the registered state and the current inputs. The pipe registers act at the next edge, so the effective latency is 0 cycles.
- Branch taken, using exmem_func[2:0]:
  - 000 beq: taken if zero.
  - 001 bne: taken if !zero.
  - 100 blt: taken if !is_greater & !zero.
  - 101 bge: taken if is_greater | zero.
  - Other encodings: not taken.
  - taken = exmem_branch & condition.
- Load-use: idex_memread & idex_rd!=0 & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2).
- Default outputs: pc_write=1, ifid_write=1, all flushes=0, pipe_hold=0, pc_src=0.
- Priority, highest first:
  1. hold = exmem_memaccess & !mem_ready, in any state.
     - Drives pipe_hold=1, pc_write=0, ifid_write=0, no flushes, pc_src=0.
     - Branch and load-use are ignored that cycle.
  2. taken.
     - Drives pc_src=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
     - PC writes the target.
  3. load-use, only when state!=RECOVER.
     - Drives pc_write=0, ifid_write=0, idex_flush=1.
- FSM transitions:
  - RUN -> MEM_WAIT on hold. RUN -> RECOVER on taken. Otherwise stay in RUN.
  - MEM_WAIT stays while hold. When hold drops, the same cycle evaluates taken: go to RECOVER if taken, else RUN.
  - RECOVER:
    - Entry loads the recover counter with BR_RECOVER-1. The counter decrements each non-held cycle, and hold freezes it.
    - Exit to RUN when the counter is 0 and hold=0.
    - A taken branch in RECOVER reloads the counter and stays in RECOVER.
    - hold in RECOVER stays in RECOVER (pipe_hold still asserted).
- Counters:
  - stall_count increments on each cycle with pc_write=0 (hold or load-use).
  - flush_count increments on each taken cycle (taken evaluated only when hold=0).
  - Both saturate at all-ones.
- Simultaneous events:
  - Taken with load-use: flush wins, no stall, stall_count unchanged.
  - hold with taken: branch deferred until mem_ready.
  - rst_n asserted mid-hold or mid-RECOVER returns immediately to the reset values.

Test Plan:
1. Reset: rst_n=0 for 3 cycles -> state=0, counters=0, all flushes=1, pc_write=0; after release with idle inputs -> pc_write=1, ifid_write=1, flushes=0.
2. Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5 -> pc_write=0, ifid_write=0, idex_flush=1 for that cycle, stall_count=1; with idex_rd=0 -> no stall.
3. Branch: exmem_branch=1, func=0000, zero=1 -> pc_src=1, all three flushes=1, flush_count=1, state=2 for 1 cycle. Next cycle load-use condition present -> suppressed; the cycle after -> stall.
4. Conditions: bne zero=1 -> not taken; blt is_greater=0, zero=0 -> taken; bge zero=1 -> taken; func=0010 -> not taken.
5. Memory wait: exmem_memaccess=1, mem_ready=0 for 4 cycles with taken asserted -> pipe_hold=1, pc_src=0, stall_count=4, state=1. Then mem_ready=1 -> pc_src=1 that cycle, state=2 next.
6. Saturation/reset: preload counters to 0xFFFFFFFF via repeated stalls (force) -> remain at 0xFFFFFFFF; assert rst_n=0 during MEM_WAIT -> state=0, counters=0 asynchronously.
